// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// N_MASTERS must match the arbiter instance it is connected to.
interface bus_arbiter_rr_if #(
    parameter int N_MASTERS = 4
);
    localparam int ID_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] grant;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_change;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  grant_change
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output grant_change
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Parked N-master bus arbiter, fixed-priority or round-robin, with an optional
// hold limit that forces handover while other masters are waiting.
module bus_arbiter_rr #(
    parameter int N_MASTERS = 4,
    parameter int MODE      = 1,
    parameter int MAX_HOLD  = 16
) (
    input  logic              clk,
    input  logic              reset,
    bus_arbiter_rr_if.slave   bus
);
    localparam int ID_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [N_MASTERS-1:0] ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};

    logic [ID_W-1:0]      owner_q, owner_d;
    logic [CNT_W-1:0]     hold_q, hold_d;
    logic                 chg_q, chg_d;
    logic [N_MASTERS-1:0] grant_vec;
    logic [N_MASTERS-1:0] others;
    logic                 own_req;
    logic                 expire;

    // Any MODE other than 0 falls through to the round-robin scan.
    function automatic logic [ID_W-1:0] pick_winner(
        input logic [N_MASTERS-1:0] cand,
        input logic [ID_W-1:0]      cur
    );
        logic [ID_W-1:0] win;
        logic            found;
        int              idx;
        win   = cur;
        found = 1'b0;
        idx   = 0;
        if (MODE == 0) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!found && cand[ID_W'(i)]) begin
                    win   = ID_W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k < N_MASTERS; k++) begin
                idx = int'(cur) + k;
                if (idx >= N_MASTERS) begin
                    idx = idx - N_MASTERS;
                end
                if (!found && cand[ID_W'(idx)]) begin
                    win   = ID_W'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

    assign grant_vec = ONE << owner_q;
    assign others    = bus.req & ~grant_vec;
    assign own_req   = bus.req[owner_q];
    assign expire    = (MAX_HOLD != 0) && (hold_q == CNT_W'(HOLD_LAST)) && (|others);

    always_comb begin
        owner_d = owner_q;
        hold_d  = '0;
        chg_d   = 1'b0;
        if (own_req && !expire) begin
            // Saturate so a lone owner keeps the bus indefinitely.
            if (hold_q != CNT_W'(HOLD_LAST)) begin
                hold_d = hold_q + CNT_W'(1);
            end else begin
                hold_d = hold_q;
            end
        end else if (|others) begin
            owner_d = pick_winner(others, owner_q);
            chg_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= '0;
            hold_q  <= '0;
            chg_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
            chg_q   <= chg_d;
        end
    end

    assign bus.grant        = grant_vec;
    assign bus.grant_id     = owner_q;
    assign bus.grant_change = chg_q;
endmodule
